pwm_ctrl: RTL
=============

Name: pwm_ctrl

Overview:
- Register-programmable PWM controller. It sits behind the TL-UL register adapter and receives its re/we/addr/wdata strobes; it returns rdata to the adapter.
- Holds configuration registers and a shared prescaler and period counter. Drives NumCh PWM outputs.
- PERIOD and DUTY changes are double-buffered and take effect only at a period boundary, so writes never produce a glitched cycle.
- Raises a period-end interrupt.

Parameters:
- NumCh, 2, number of PWM channels (1..4).
- CntW, 16, width of the prescaler, period counter, PERIOD and DUTY fields.
- RegAw, 8, register address width; must match the adapter.
- RegDw, 32, register data width; must match the adapter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- re_i  in  1  register read strobe from the adapter.
- we_i  in  1  register write strobe from the adapter.
- addr_i  in  RegAw  byte address. Bits [1:0] are ignored.
- wdata_i  in  RegDw  write data. Full-word writes only.
- rdata_o  out  RegDw  read data. Combinational from addr_i.
- pwm_o  out  NumCh  PWM outputs. Registered.
- intr_o  out  1  period-end interrupt. Level, registered.

Behaviour:
- Interface (already decided): one clock, clk_i. Reset rst_i is synchronous and active-high. All state is updated on the rising edge of clk_i.
- Reset values:
  - All registers, staging and active copies, prescaler count, period count, pwm_o and intr_o are 0.
  - rdata_o is 0 whenever re_i=0.
- Register map:
  - 0x00 CTRL: [NumCh-1:0] channel enable; [31] IE (interrupt enable).
  - 0x04 PRESC: [CntW-1:0].
  - 0x08 PERIOD: [CntW-1:0], staging copy.
  - 0x0C+4*ch DUTY[ch]: [CntW-1:0], staging copy.
  - 0x1C STATUS: [0] PEND, sticky. Write 1 to clear.
  - 0x20 COUNT: read-only, current period count.
- Register access rules:
  - Unmapped addresses read 0 and ignore writes.
  - Reads of PERIOD and DUTY return the staging value.
  - Unused register bits read 0.
- Run state: run = |CTRL enable bits.
  - While run=0: prescaler and count are held at 0, and the active PERIOD/DUTY copies load from staging every cycle.
- Prescaler (while run=1):
  - presc_cnt counts 0..PRESC.
  - tick = (presc_cnt == PRESC); on tick, presc_cnt returns to 0.
  - PRESC=0 gives a tick every cycle.
- Period counter:
  - On tick, count increments.
  - If count == active PERIOD, count wraps to 0 instead and a wrap event fires.
  - Period length = (PERIOD+1)*(PRESC+1) clocks.
  - PERIOD=0 gives a wrap on every tick.
- Wrap event: in the same cycle, both active copies load from staging and STATUS.PEND is set.
- Output compare: pwm_o[ch] <= en[ch] & (count < active DUTY[ch]); one cycle of latency from count.
  - DUTY=0: output constantly low.
  - DUTY > PERIOD: output constantly high.
  - A disabled channel drives 0 on the next cycle.
- Interrupt: intr_o <= PEND & IE.
  - A wrap coinciding with a W1C write of PEND leaves PEND set (set wins).
- Writes to PRESC take effect immediately. If the new PRESC is below the current presc_cnt, the prescaler runs to its CntW-bit wrap, 2^CntW-1 → 0. This is documented behaviour, not an error.
- Simultaneous accesses:
  - re_i and we_i in the same cycle: the write is performed, and rdata_o shows the pre-write value.
  - A DUTY write landing on the wrap cycle goes to staging only; it is applied at the next wrap.
- Enabling from idle: the first tick occurs PRESC+1 clocks after the CTRL write, and count starts from 0.
- Reset asserted mid-period: everything returns to reset values on the next edge; there is no residual output pulse.

Decomposition:
- pwm_pkg holds:
  - register offset localparams: CTRL_OFS, PRESC_OFS, PERIOD_OFS, DUTY_BASE_OFS, STATUS_OFS, COUNT_OFS;
  - the CTRL bit index for IE;
  - typedef pwm_cfg_t as a packed struct of the PERIOD and DUTY arrays.
- One sub-module: pwm_channel. It holds the per-channel staging/active DUTY, the compare and the output flop. It is instantiated NumCh times by generate.
- The register decode, prescaler and period counter stay in pwm_ctrl.

Test Plan:
1. Reset, then read all registers → every mapped register reads 0; pwm_o=0 and intr_o=0.
2. PRESC=0, PERIOD=9, DUTY0=3, CTRL=0x1 → pwm_o[0] is high 3 of every 10 clocks; pwm_o[1] stays 0; COUNT cycles 0..9.
3. PRESC=1, PERIOD=4, DUTY0=5 and DUTY1=0, enable both → period is 10 clocks; pwm_o[0] is constantly 1 and pwm_o[1] is constantly 0.
4. While running with DUTY0=3, write DUTY0=7 mid-period → the current period keeps high-time 3; the next period onward has high-time 7; the DUTY0 read returns 7 immediately.
5. CTRL=0x8000_0001, PERIOD=3 → intr_o rises 1 cycle after the first wrap. W1C on STATUS drops intr_o. A W1C issued in the exact wrap cycle leaves PEND=1.
6. Assert rst_i mid-period while pwm_o=1 → the next cycle has pwm_o=0, COUNT=0 and all registers 0. After release, the outputs stay idle until re-enabled.

Source files
------------

// File: rtl/pwm_pkg.sv
// Register map, CTRL bit positions and the staging-configuration view shared by
// pwm_ctrl and its testbench-visible register file.
package pwm_pkg;

  localparam int PWM_NUM_CH = 2;
  localparam int PWM_CNT_W  = 16;

  localparam logic [7:0] CTRL_OFS      = 8'h00;
  localparam logic [7:0] PRESC_OFS     = 8'h04;
  localparam logic [7:0] PERIOD_OFS    = 8'h08;
  localparam logic [7:0] DUTY_BASE_OFS = 8'h0C;
  localparam logic [7:0] STATUS_OFS    = 8'h1C;
  localparam logic [7:0] COUNT_OFS     = 8'h20;

  localparam int CTRL_IE_BIT = 31;

  // Staging (software-visible) PERIOD and DUTY values; sized to the default build.
  typedef struct packed {
    logic [PWM_CNT_W-1:0]                 period;
    logic [PWM_NUM_CH-1:0][PWM_CNT_W-1:0] duty;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered DUTY (staging + active) and the registered
// compare against the shared period count.
module pwm_channel #(
  parameter int CntW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic            we,
  input  logic [CntW-1:0] wdata,
  input  logic [CntW-1:0] count,
  output logic [CntW-1:0] duty,
  output logic            pwm
);

  logic [CntW-1:0] duty_act;

  // Active duty only changes on load so a mid-period write never glitches the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty     <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (we) begin
        duty <= wdata;
      end
      if (load) begin
        duty_act <= duty;
      end
      pwm <= en & (count < duty_act);
    end
  end

endmodule

// File: rtl/pwm_ctrl.sv
// Register-programmable PWM controller: register decode, shared prescaler and
// period counter, period-end interrupt, and NumCh pwm_channel instances.
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int NumCh = PWM_NUM_CH,
  parameter int CntW  = PWM_CNT_W,
  parameter int RegAw = 8,
  parameter int RegDw = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [RegAw-1:0] addr_i,
  input  logic [RegDw-1:0] wdata_i,
  output logic [RegDw-1:0] rdata_o,
  output logic [NumCh-1:0] pwm_o,
  output logic             intr_o
);

  // The staging view type comes from the package, so its sizing must track ours.
  if (NumCh != PWM_NUM_CH || CntW != PWM_CNT_W) begin : g_cfg_check
    $error("pwm_ctrl: NumCh/CntW must match pwm_pkg sizing of pwm_cfg_t");
  end

  logic [RegAw-1:0]            addr_word;
  logic [NumCh-1:0]            ctrl_en;
  logic                        ctrl_ie;
  logic [CntW-1:0]             presc;
  logic [CntW-1:0]             period_stage;
  logic [CntW-1:0]             period_act;
  logic [CntW-1:0]             presc_cnt;
  logic [CntW-1:0]             count;
  logic                        pend;
  logic                        run;
  logic                        tick;
  logic                        wrap;
  logic                        load;
  logic [NumCh-1:0]            duty_we;
  logic [NumCh-1:0][CntW-1:0]  duty_stage;
  pwm_cfg_t                    cfg;
  logic                        unused_bits;

  assign addr_word   = {addr_i[RegAw-1:2], 2'b00};
  assign run         = |ctrl_en;
  assign tick        = run && (presc_cnt == presc);
  assign wrap        = tick && (count == period_act);
  assign load        = !run || wrap;
  assign cfg         = {period_stage, duty_stage};
  assign unused_bits = ^{addr_i[1:0], wdata_i[RegDw-2:CntW]};

  // Control registers, prescaler, period counter and sticky pending flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en      <= '0;
      ctrl_ie      <= 1'b0;
      presc        <= '0;
      period_stage <= '0;
      period_act   <= '0;
      presc_cnt    <= '0;
      count        <= '0;
      pend         <= 1'b0;
      intr_o       <= 1'b0;
    end else begin
      if (we_i && addr_word == RegAw'(CTRL_OFS)) begin
        ctrl_en <= wdata_i[NumCh-1:0];
        ctrl_ie <= wdata_i[CTRL_IE_BIT];
      end
      if (we_i && addr_word == RegAw'(PRESC_OFS)) begin
        presc <= wdata_i[CntW-1:0];
      end
      if (we_i && addr_word == RegAw'(PERIOD_OFS)) begin
        period_stage <= wdata_i[CntW-1:0];
      end
      if (load) begin
        period_act <= period_stage;
      end

      if (!run) begin
        presc_cnt <= '0;
        count     <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        count     <= wrap ? '0 : count + CntW'(1);
      end else begin
        presc_cnt <= presc_cnt + CntW'(1);
      end

      // A wrap in the same cycle as a W1C keeps PEND set.
      if (wrap) begin
        pend <= 1'b1;
      end else if (we_i && addr_word == RegAw'(STATUS_OFS) && wdata_i[0]) begin
        pend <= 1'b0;
      end
      intr_o <= pend & ctrl_ie;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (re_i) begin
      if (addr_word == RegAw'(CTRL_OFS)) begin
        rdata_o[NumCh-1:0]    = ctrl_en;
        rdata_o[CTRL_IE_BIT]  = ctrl_ie;
      end else if (addr_word == RegAw'(PRESC_OFS)) begin
        rdata_o = RegDw'(presc);
      end else if (addr_word == RegAw'(PERIOD_OFS)) begin
        rdata_o = RegDw'(cfg.period);
      end else if (addr_word == RegAw'(STATUS_OFS)) begin
        rdata_o = RegDw'(pend);
      end else if (addr_word == RegAw'(COUNT_OFS)) begin
        rdata_o = RegDw'(count);
      end
      for (int i = 0; i < NumCh; i++) begin
        if (addr_word == RegAw'(DUTY_BASE_OFS) + RegAw'(4 * i)) begin
          rdata_o = RegDw'(cfg.duty[i]);
        end
      end
    end
  end

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    assign duty_we[i] = we_i && (addr_word == RegAw'(DUTY_BASE_OFS) + RegAw'(4 * i));

    pwm_channel #(
      .CntW (CntW)
    ) u_ch (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (ctrl_en[i]),
      .load  (load),
      .we    (duty_we[i]),
      .wdata (wdata_i[CntW-1:0]),
      .count (count),
      .duty  (duty_stage[i]),
      .pwm   (pwm_o[i])
    );
  end

endmodule
